fp_normalize_round: RTL

- Consumer end of the FPU prenormalization interface: takes the selected shift direction/amount, precomputed DP/SP exponents and overflow flags, plus the raw significand.
- Performs the normalization shift with sticky collection, rounds per RISC-V rounding mode, and packs an IEEE-754 result with fflags.
- Two-stage pipeline (shift, round/pack) with valid/ready handshake on both sides.
- Sits between prenormalization and the FP writeback arbiter.

---
 rtl/fp_normalize_round_pkg.sv | 44 ++++
 rtl/fp_normalize_round_round.sv | 60 ++++++
 rtl/fp_normalize_round.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp_normalize_round_pkg.sv
// Shared FPU types: shift-amount and exponent widths, rounding modes,
// packed-result constants and the stage-1 payload carried into rounding.
package fpu_types;

  localparam int SIG_W    = 55;
  localparam int EXPO_D_W = 11;
  localparam int EXPO_S_W = 8;

  typedef logic [5:0]          fp_shift_amt_t;
  typedef logic [EXPO_D_W-1:0] fp_expo_d_t;
  typedef logic [EXPO_S_W-1:0] fp_expo_s_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam logic [31:0] SP_MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] SP_INF        = 32'h7F80_0000;
  localparam logic [63:0] DP_MAX_FINITE = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DP_INF        = 64'h7FF0_0000_0000_0000;

  typedef struct packed {
    logic [SIG_W-1:0] sig;
    logic             sticky;
    fp_expo_d_t       expo;
    logic             ovf;
    logic             sign;
    rm_e              rm;
    logic             single;
    logic             special;
    logic [63:0]      special_result;
  } s1_payload_t;

  // Reserved encodings 5-7 behave as round-to-nearest-even.
  function automatic rm_e rm_norm(input logic [2:0] raw);
    if (raw > 3'd4) return RM_RNE;
    return rm_e'(raw);
  endfunction

endpackage

// File: rtl/fp_normalize_round_round.sv
// Combinational rounder: applies the rounding increment to the kept
// significand and resolves carry, subnormal promotion, overflow and flags.
module fp_round
  import fpu_types::*;
(
  input  logic [52:0] keep,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  input  logic        sign,
  input  rm_e         rm,
  input  fp_expo_d_t  expo,
  input  logic        single,
  input  logic        ovf_in,
  output logic [51:0] frac,
  output fp_expo_d_t  expo_out,
  output logic        of,
  output logic        uf,
  output logic        nx,
  output logic        to_inf
);

  logic        grs;
  logic        inc;
  logic [53:0] sum;
  logic        carry;
  logic        hidden;
  logic [11:0] expo_sum;
  logic [11:0] expo_max;

  always_comb begin
    grs = g | r | s;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & grs;
      RM_RUP:  inc = ~sign & grs;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | keep[0]);
    endcase

    sum    = {1'b0, keep} + 54'(inc);
    carry  = single ? sum[24] : sum[53];
    hidden = single ? sum[23] : sum[52];
    frac   = single ? {29'b0, sum[22:0]} : sum[51:0];
    if (carry) frac = '0;

    expo_sum = {1'b0, expo} + 12'(carry);
    // A subnormal that rounds up into the hidden bit becomes the minimum normal.
    if (expo == '0 && hidden && !carry) expo_sum = 12'd1;
    expo_max = single ? 12'h0FF : 12'h7FF;

    of       = ovf_in | (expo_sum >= expo_max);
    expo_out = expo_sum[10:0];
    nx       = grs | of;
    uf       = nx & ~of & (expo_sum == 12'd0);
    to_inf   = (rm == RM_RNE) | (rm == RM_RMM) |
               ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalize (shift + sticky) and round/pack pipeline sitting
// between FPU prenormalization and the writeback arbiter.
module fp_normalize_round
  import fpu_types::*;
#(
  parameter int FRAC_W  = 52,
  parameter int SHIFT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                single,
  input  logic                right_shift,
  input  logic [SHIFT_W-1:0]  shift_amt,
  input  logic [10:0]         expo_d,
  input  logic [7:0]          expo_s,
  input  logic                dp_overflow,
  input  logic                sp_overflow,
  input  logic                sign,
  input  logic [2:0]          rm,
  input  logic [FRAC_W+2:0]   sig,
  input  logic                sticky,
  input  logic                special,
  input  logic [63:0]         special_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         result,
  output logic [4:0]          fflags
);

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  s1_payload_t s1_q, s1_d, s1_in;
  logic [63:0] result_q, result_d;
  logic [4:0]  fflags_q, fflags_d;

  logic              s1_adv;
  logic              accept;
  logic [FRAC_W+2:0] ones;
  logic [FRAC_W+2:0] sh_sig;
  logic              lost;

  assign s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s1_adv;
  assign accept   = in_valid & in_ready & ~flush;

  // Oversized right shifts clear the whole mask, so every bit lands in sticky.
  always_comb begin
    ones = '1;
    if (right_shift) begin
      sh_sig = sig >> shift_amt;
      lost   = |(sig & ~(ones << shift_amt));
    end else begin
      sh_sig = sig << shift_amt;
      lost   = 1'b0;
    end

    s1_in.sig            = sh_sig;
    s1_in.sticky         = sticky | lost;
    s1_in.expo           = single ? {3'b000, expo_s} : expo_d;
    s1_in.ovf            = single ? sp_overflow : dp_overflow;
    s1_in.sign           = sign;
    s1_in.rm             = rm_norm(rm);
    s1_in.single         = single;
    s1_in.special        = special;
    s1_in.special_result = special_result;
  end

  logic [52:0] keep;
  logic        rg, rr, rs;
  logic [51:0] rnd_frac;
  fp_expo_d_t  rnd_expo;
  logic        rnd_of, rnd_uf, rnd_nx, rnd_inf;
  logic [63:0] packed_result;

  always_comb begin
    if (s1_q.single) begin
      keep = {29'b0, s1_q.sig[54:31]};
      rg   = s1_q.sig[30];
      rr   = s1_q.sig[29];
      rs   = (|s1_q.sig[28:0]) | s1_q.sticky;
    end else begin
      keep = s1_q.sig[54:2];
      rg   = s1_q.sig[1];
      rr   = s1_q.sig[0];
      rs   = s1_q.sticky;
    end
  end

  fp_round u_round (
    .keep     (keep),
    .g        (rg),
    .r        (rr),
    .s        (rs),
    .sign     (s1_q.sign),
    .rm       (s1_q.rm),
    .expo     (s1_q.expo),
    .single   (s1_q.single),
    .ovf_in   (s1_q.ovf),
    .frac     (rnd_frac),
    .expo_out (rnd_expo),
    .of       (rnd_of),
    .uf       (rnd_uf),
    .nx       (rnd_nx),
    .to_inf   (rnd_inf)
  );

  always_comb begin
    if (s1_q.single) begin
      if (rnd_of)
        packed_result = {32'hFFFF_FFFF, s1_q.sign,
                         rnd_inf ? SP_INF[30:0] : SP_MAX_FINITE[30:0]};
      else
        packed_result = {32'hFFFF_FFFF, s1_q.sign, rnd_expo[7:0], rnd_frac[22:0]};
    end else begin
      if (rnd_of)
        packed_result = {s1_q.sign, rnd_inf ? DP_INF[62:0] : DP_MAX_FINITE[62:0]};
      else
        packed_result = {s1_q.sign, rnd_expo, rnd_frac};
    end
  end

  // Flush outranks every advance; payload registers simply hold when not loaded.
  always_comb begin
    s1_d       = accept ? s1_in : s1_q;
    s1_valid_d = s1_valid_q;
    if (flush)       s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (flush)          s2_valid_d = 1'b0;
    else if (s1_adv)    s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;

    result_d = result_q;
    fflags_d = fflags_q;
    if (s1_adv && !flush) begin
      if (s1_q.special) begin
        result_d = s1_q.special_result;
        fflags_d = '0;
      end else begin
        result_d = packed_result;
        fflags_d = {2'b00, rnd_of, rnd_uf, rnd_nx};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      result_q   <= '0;
      fflags_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      result_q   <= result_d;
      fflags_q   <= fflags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign fflags    = fflags_q;

endmodule
